// File: rtl/sounder_tx.sv
// sounder_tx: channel-sounder transmit source.
//
// Replays a pilot sequence held in an internal block RAM as an AXI-Stream
// beat source. A frame is NANT antenna slots, each made of P guard beats of
// zeros followed by the sequence (L beats) repeated M times. After the last
// slot come R rest beats of zeros. ant_sel follows the antenna of the beat
// currently on the bus.
//
// Optional feature macro: SOUNDER_TX_TRIG_EN
//   When defined, adds input trig. Every frame then waits in WAIT_TRIG, with
//   tvalid low, until a trig=1 cycle.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   seq_we/addr/wdata sequence RAM write port (address in beats)
//   en                run enable; a frame in progress always completes
//   l, m, p, r        sequence length, repetitions, guard beats, rest beats
//   nant, spp         antennas per frame, beats per packet (0 = no packets)
//   o_axis_*          AXI-Stream master (tdata/tkeep/tlast/tvalid/tready)
//   ant_sel           antenna index of the beat on the bus
//   frame_start       high on the accepted first beat of each frame
module sounder_tx #(
  parameter int WIDTH  = 32,
  parameter int NIPC   = 2,
  parameter int AWIDTH = 12
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    seq_we,
  input  logic [AWIDTH-1:0]       seq_addr,
  input  logic [NIPC*WIDTH-1:0]   seq_wdata,
  input  logic                    en,
`ifdef SOUNDER_TX_TRIG_EN
  input  logic                    trig,
`endif
  input  logic [AWIDTH:0]         l,
  input  logic [7:0]              m,
  input  logic [31:0]             p,
  input  logic [31:0]             r,
  input  logic [7:0]              nant,
  input  logic [15:0]             spp,
  output logic [NIPC*WIDTH-1:0]   o_axis_tdata,
  output logic [NIPC-1:0]         o_axis_tkeep,
  output logic                    o_axis_tlast,
  output logic                    o_axis_tvalid,
  input  logic                    o_axis_tready,
  output logic [7:0]              ant_sel,
  output logic                    frame_start
);

  localparam int DW  = NIPC * WIDTH;
  localparam int LMW = 20;
  localparam logic [31:0]       ONE32 = 32'd1;
  localparam logic [15:0]       ONE16 = 16'd1;
  localparam logic [7:0]        ONE8  = 8'd1;
  localparam logic [AWIDTH:0]   ONEL  = 1;
  localparam logic [AWIDTH-1:0] ONEA  = 1;

  typedef enum logic [2:0] {S_IDLE, S_WAIT_TRIG, S_GUARD, S_ACTIVE, S_REST} state_t;

  // Beat generator: describes the next beat to be loaded into the output register.
  state_t            state_q, state_d;
  logic [31:0]       cnt_q, cnt_d;       // beat index inside the current phase
  logic [AWIDTH-1:0] addr_q, addr_d;
  logic [7:0]        ant_q, ant_d;
  logic              first_q, first_d;   // next beat is the first of its frame
  logic [15:0]       pkt_q, pkt_d;
  logic [AWIDTH:0]   cfg_l_q, cfg_l_d;
  logic [7:0]        cfg_m_q, cfg_m_d;
  logic [31:0]       cfg_p_q, cfg_p_d;
  logic [31:0]       cfg_r_q, cfg_r_d;
  logic [7:0]        cfg_nant_q, cfg_nant_d;
  logic [15:0]       cfg_spp_q, cfg_spp_d;

  // Output register.
  logic          tvalid_q, tlast_q, fs_q;
  logic [DW-1:0] tdata_q;
  logic [7:0]    ant_sel_q;

  logic [DW-1:0] mem [2**AWIDTH];
  logic [DW-1:0] rd_q;

  logic          beat_valid, load, start_ok, final_beat, last_beat;
  logic          slot_end, frame_end, begin_frame;
  logic [LMW-1:0] lm;
  logic [31:0]   lm32;

  assign beat_valid = (state_q == S_GUARD) || (state_q == S_ACTIVE) || (state_q == S_REST);
  assign load       = beat_valid && (!tvalid_q || o_axis_tready);
  assign start_ok   = en && (l != '0) && (m != '0) && (nant != '0);
  assign lm         = LMW'(cfg_l_q) * LMW'(cfg_m_q);
  assign lm32       = {{(32-LMW){1'b0}}, lm};

  // The RAM is addressed with the generator's next address, so rd_q always
  // holds the word for addr_q; this is what keeps the stream bubble-free.
  always_ff @(posedge clk) begin
    if (seq_we) mem[seq_addr] <= seq_wdata;
    rd_q <= mem[addr_d];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      ant_q      <= '0;
      first_q    <= 1'b0;
      pkt_q      <= ONE16;
      cfg_l_q    <= '0;
      cfg_m_q    <= '0;
      cfg_p_q    <= '0;
      cfg_r_q    <= '0;
      cfg_nant_q <= '0;
      cfg_spp_q  <= '0;
      tvalid_q   <= 1'b0;
      tlast_q    <= 1'b0;
      fs_q       <= 1'b0;
      tdata_q    <= '0;
      ant_sel_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      ant_q      <= ant_d;
      first_q    <= first_d;
      pkt_q      <= pkt_d;
      cfg_l_q    <= cfg_l_d;
      cfg_m_q    <= cfg_m_d;
      cfg_p_q    <= cfg_p_d;
      cfg_r_q    <= cfg_r_d;
      cfg_nant_q <= cfg_nant_d;
      cfg_spp_q  <= cfg_spp_d;
      if (load) begin
        tvalid_q  <= 1'b1;
        tdata_q   <= (state_q == S_ACTIVE) ? rd_q : '0;
        tlast_q   <= last_beat;
        fs_q      <= first_q;
        ant_sel_q <= ant_q;
      end else if (o_axis_tready) begin
        tvalid_q <= 1'b0;
        tlast_q  <= 1'b0;
        fs_q     <= 1'b0;
        tdata_q  <= '0;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    ant_d       = ant_q;
    first_d     = first_q;
    cfg_l_d     = cfg_l_q;
    cfg_m_d     = cfg_m_q;
    cfg_p_d     = cfg_p_q;
    cfg_r_d     = cfg_r_q;
    cfg_nant_d  = cfg_nant_q;
    cfg_spp_d   = cfg_spp_q;
    slot_end    = 1'b0;
    frame_end   = 1'b0;
    begin_frame = 1'b0;
    final_beat  = 1'b0;
    if (load) first_d = 1'b0;
    case (state_q)
      S_IDLE: begin_frame = start_ok;
`ifdef SOUNDER_TX_TRIG_EN
      S_WAIT_TRIG: if (trig) state_d = (cfg_p_q != '0) ? S_GUARD : S_ACTIVE;
`endif
      S_GUARD: if (load) begin
        if (cnt_q == cfg_p_q - ONE32) begin
          cnt_d   = '0;
          addr_d  = '0;
          state_d = S_ACTIVE;
        end else begin
          cnt_d = cnt_q + ONE32;
        end
      end
      S_ACTIVE: if (load) begin
        addr_d = ({1'b0, addr_q} == cfg_l_q - ONEL) ? '0 : addr_q + ONEA;
        if (cnt_q == lm32 - ONE32) slot_end = 1'b1;
        else                       cnt_d    = cnt_q + ONE32;
      end
      S_REST: if (load) begin
        if (cnt_q == cfg_r_q - ONE32) frame_end = 1'b1;
        else                          cnt_d     = cnt_q + ONE32;
      end
      default: state_d = S_IDLE;
    endcase

    if (slot_end) begin
      cnt_d  = '0;
      addr_d = '0;
      if (ant_q < cfg_nant_q - ONE8) begin
        ant_d   = ant_q + ONE8;
        state_d = (cfg_p_q != '0) ? S_GUARD : S_ACTIVE;
      end else if (cfg_r_q != '0) begin
        state_d = S_REST;
      end else begin
        frame_end = 1'b1;
      end
    end

    if (frame_end) begin
      if (start_ok) begin
        begin_frame = 1'b1;
      end else begin
        final_beat = 1'b1;
        cnt_d      = '0;
        state_d    = S_IDLE;
      end
    end

    // Configuration is captured only here, so it is constant within a frame.
    if (begin_frame) begin
      cfg_l_d    = l;
      cfg_m_d    = m;
      cfg_p_d    = p;
      cfg_r_d    = r;
      cfg_nant_d = nant;
      cfg_spp_d  = spp;
      cnt_d      = '0;
      addr_d     = '0;
      ant_d      = '0;
      first_d    = 1'b1;
`ifdef SOUNDER_TX_TRIG_EN
      state_d    = S_WAIT_TRIG;
`else
      state_d    = (p != '0) ? S_GUARD : S_ACTIVE;
`endif
    end
  end

  always_comb begin
    // The last beat before IDLE always closes the packet.
    last_beat = final_beat || ((cfg_spp_q != '0) && (pkt_q == cfg_spp_q));
    pkt_d     = pkt_q;
    if (load) pkt_d = last_beat ? ONE16 : pkt_q + ONE16;
    o_axis_tdata  = tdata_q;
    o_axis_tkeep  = tvalid_q ? '1 : '0;
    o_axis_tlast  = tlast_q;
    o_axis_tvalid = tvalid_q;
    ant_sel       = ant_sel_q;
    frame_start   = tvalid_q & o_axis_tready & fs_q;
  end

endmodule

// File: tb/tb_sounder_tx.sv
`timescale 1ns/1ps
module tb_sounder_tx;
  localparam int WIDTH = 32, NIPC = 2, AWIDTH = 12, DW = 64;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              seq_we = 1'b0;
  logic [AWIDTH-1:0] seq_addr = '0;
  logic [DW-1:0]     seq_wdata = '0;
  logic              en = 1'b0;
  logic [AWIDTH:0]   l = '0;
  logic [7:0]        m = '0;
  logic [31:0]       p = '0;
  logic [31:0]       r = '0;
  logic [7:0]        nant = '0;
  logic [15:0]       spp = '0;
  logic [DW-1:0]     tdata;
  logic [NIPC-1:0]   tkeep;
  logic              tlast, tvalid;
  logic              tready = 1'b1;
  logic [7:0]        ant_sel;
  logic              frame_start;

  sounder_tx #(.WIDTH(WIDTH), .NIPC(NIPC), .AWIDTH(AWIDTH)) dut (
    .clk(clk), .rst(rst),
    .seq_we(seq_we), .seq_addr(seq_addr), .seq_wdata(seq_wdata),
    .en(en), .l(l), .m(m), .p(p), .r(r), .nant(nant), .spp(spp),
    .o_axis_tdata(tdata), .o_axis_tkeep(tkeep), .o_axis_tlast(tlast),
    .o_axis_tvalid(tvalid), .o_axis_tready(tready),
    .ant_sel(ant_sel), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  typedef struct { logic [63:0] data; logic [7:0] ant; logic last; logic fs; } beat_t;
  typedef struct { int idx; int ant; bit last; bit fs; } row_t;

  beat_t       exp_q[$];
  row_t        s1_tab [17];
  logic [63:0] ram_model [16];
  int          model_pkt = 0;
  int          total = 0;
  int          bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; tready = 1'b1;
    tick(); tick();
    rst = 1'b0;
    exp_q.delete();
    model_pkt = 0;
  endtask

  task automatic write_ram(input int a, input logic [63:0] d);
    seq_we = 1'b1; seq_addr = AWIDTH'(a); seq_wdata = d;
    ram_model[a] = d;
    tick();
    seq_we = 1'b0;
  endtask

  task automatic set_cfg(input int fl, input int fm, input int fp, input int fr,
                         input int fn, input int fspp);
    l = 13'(fl); m = 8'(fm); p = 32'(fp); r = 32'(fr); nant = 8'(fn); spp = 16'(fspp);
  endtask

  // Reference: a packet counts beats in stream order and closes at spp
  // beats, or on the last beat before the source stops.
  task automatic push_beat(input logic [63:0] d, input int a, input bit fs,
                           input bit fin, input int fspp);
    beat_t b;
    model_pkt++;
    b.data = d; b.ant = 8'(a); b.fs = fs;
    b.last = fin || (fspp != 0 && model_pkt == fspp);
    if (b.last) model_pkt = 0;
    exp_q.push_back(b);
  endtask

  // Reference frame: per antenna, fp zeros then the sequence repeated fm
  // times; then fr zeros.
  task automatic model_frame(input int fl, input int fm, input int fp, input int fr,
                             input int fn, input int fspp, input bit final_frame);
    int n, idx;
    n = fn * (fp + fl * fm) + fr;
    idx = 0;
    for (int a = 0; a < fn; a++) begin
      for (int i = 0; i < fp; i++) begin
        push_beat(64'd0, a, idx == 0, final_frame && idx == n - 1, fspp); idx++;
      end
      for (int k = 0; k < fl * fm; k++) begin
        push_beat(ram_model[k % fl], a, idx == 0, final_frame && idx == n - 1, fspp); idx++;
      end
    end
    for (int i = 0; i < fr; i++) begin
      push_beat(64'd0, fn - 1, idx == 0, final_frame && idx == n - 1, fspp); idx++;
    end
  endtask

  task automatic run_beats(input int nbeats, input bit rnd_ready, input int drop_en_after,
                           input int max_cycles);
    int got, cyc, bubbles;
    bit started, stall, hold_l;
    logic [63:0] hold_d;
    beat_t e;
    got = 0; cyc = 0; bubbles = 0; started = 0; stall = 0; hold_l = 0; hold_d = '0;
    while (got < nbeats && cyc < max_cycles) begin
      tready = rnd_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
      #1;
      if (stall) begin
        check("hold_data", tdata, hold_d);
        check("hold_ctl", 64'({tvalid, tlast}), 64'({1'b1, hold_l}));
      end
      if (tvalid) started = 1;
      else if (started) bubbles++;
      if (tvalid && tready) begin
        $display("beat %0d data=%h ant=%0d last=%b fs=%b", got, tdata, ant_sel, tlast, frame_start);
        if (exp_q.size() == 0) begin
          check("model_underflow", 64'(got), 64'(-1));
        end else begin
          e = exp_q.pop_front();
          check("tdata", tdata, e.data);
          check("ant_sel", 64'(ant_sel), 64'(e.ant));
          check("tlast", 64'(tlast), 64'(e.last));
          check("frame_start", 64'(frame_start), 64'(e.fs));
          check("tkeep", 64'(tkeep), 64'(2'b11));
        end
        got++;
        if (got == drop_en_after) en = 1'b0;
      end
      stall = tvalid && !tready;
      hold_d = tdata; hold_l = tlast;
      @(posedge clk); #1;
      cyc++;
    end
    check("beats_accepted", 64'(got), 64'(nbeats));
    if (!rnd_ready) check("bubbles", 64'(bubbles), 64'd0);
  endtask

  initial begin
    logic [63:0] va, vb, vc, vx;
    s1_tab[0]  = '{-1, 0, 1'b0, 1'b1};
    s1_tab[1]  = '{-1, 0, 1'b0, 1'b0};
    s1_tab[2]  = '{ 0, 0, 1'b0, 1'b0};
    s1_tab[3]  = '{ 1, 0, 1'b1, 1'b0};
    s1_tab[4]  = '{ 2, 0, 1'b0, 1'b0};
    s1_tab[5]  = '{ 0, 0, 1'b0, 1'b0};
    s1_tab[6]  = '{ 1, 0, 1'b0, 1'b0};
    s1_tab[7]  = '{ 2, 0, 1'b1, 1'b0};
    s1_tab[8]  = '{-1, 1, 1'b0, 1'b0};
    s1_tab[9]  = '{-1, 1, 1'b0, 1'b0};
    s1_tab[10] = '{ 0, 1, 1'b0, 1'b0};
    s1_tab[11] = '{ 1, 1, 1'b1, 1'b0};
    s1_tab[12] = '{ 2, 1, 1'b0, 1'b0};
    s1_tab[13] = '{ 0, 1, 1'b0, 1'b0};
    s1_tab[14] = '{ 1, 1, 1'b0, 1'b0};
    s1_tab[15] = '{ 2, 1, 1'b1, 1'b0};
    s1_tab[16] = '{-1, 1, 1'b0, 1'b0};
    for (int i = 0; i < 16; i++) ram_model[i] = '0;

    // Reset state
    tick();
    check("reset_tvalid", 64'(tvalid), 64'd0);
    check("reset_tlast", 64'(tlast), 64'd0);
    check("reset_tdata", tdata, 64'd0);
    check("reset_ant_sel", 64'(ant_sel), 64'd0);
    check("reset_tkeep", 64'(tkeep), 64'd0);
    do_reset();

    // Scenario 1: table-checked first frame, then two modelled frames.
    va = {$urandom, $urandom}; vb = {$urandom, $urandom}; vc = {$urandom, $urandom};
    write_ram(0, va); write_ram(1, vb); write_ram(2, vc);
    set_cfg(3, 2, 2, 1, 2, 4);
    en = 1'b1;
    tick();
    check("latency_cycle1", 64'(tvalid), 64'd0);
    tick();
    check("latency_cycle2", 64'(tvalid), 64'd1);
    for (int i = 0; i < 17; i++) begin
      beat_t b;
      b.data = (s1_tab[i].idx < 0) ? 64'd0 : ram_model[s1_tab[i].idx];
      b.ant = 8'(s1_tab[i].ant); b.last = s1_tab[i].last; b.fs = s1_tab[i].fs;
      exp_q.push_back(b);
    end
    model_pkt = 1;   // 17 beats since reset, last tlast on beat 16
    model_frame(3, 2, 2, 1, 2, 4, 1'b0);
    model_frame(3, 2, 2, 1, 2, 4, 1'b0);
    run_beats(51, 1'b0, 0, 200);

    // Scenario 2: random backpressure, same accepted stream.
    do_reset();
    set_cfg(3, 2, 2, 1, 2, 4);
    en = 1'b1;
    for (int f = 0; f < 3; f++) model_frame(3, 2, 2, 1, 2, 4, 1'b0);
    run_beats(51, 1'b1, 0, 1000);

    // Scenario 3: one-beat frames.
    do_reset();
    vx = {$urandom, $urandom};
    write_ram(0, vx);
    set_cfg(1, 1, 0, 0, 1, 3);
    en = 1'b1;
    for (int f = 0; f < 20; f++) model_frame(1, 1, 0, 0, 1, 3, 1'b0);
    run_beats(20, 1'b0, 0, 100);

    // Scenario 4: en drops during antenna 0 ACTIVE; frame finishes with tlast.
    do_reset();
    write_ram(0, va);
    set_cfg(3, 2, 2, 1, 2, 4);
    en = 1'b1;
    model_frame(3, 2, 2, 1, 2, 4, 1'b1);
    run_beats(17, 1'b0, 4, 200);
    for (int i = 0; i < 4; i++) begin
      check("idle_after_final", 64'(tvalid), 64'd0);
      tick();
    end

    // Scenario 5: reset in the antenna-1 guard, en held high.
    do_reset();
    set_cfg(3, 2, 5, 1, 2, 4);
    en = 1'b1;
    tick(); tick();
    model_frame(3, 2, 5, 1, 2, 4, 1'b0);
    run_beats(13, 1'b0, 0, 100);
    check("pre_rst_ant_sel", 64'(ant_sel), 64'd1);
    rst = 1'b1;
    tick();
    check("rst_tvalid", 64'(tvalid), 64'd0);
    check("rst_ant_sel", 64'(ant_sel), 64'd0);
    check("rst_tlast", 64'(tlast), 64'd0);
    rst = 1'b0;
    exp_q.delete();
    model_pkt = 0;
    tick();
    check("restart_cycle1", 64'(tvalid), 64'd0);
    tick();
    check("restart_tvalid", 64'(tvalid), 64'd1);
    check("restart_tdata", tdata, 64'd0);
    check("restart_ant_sel", 64'(ant_sel), 64'd0);
    model_frame(3, 2, 5, 1, 2, 4, 1'b0);
    run_beats(23, 1'b0, 0, 100);

    // Randomised configurations under random backpressure.
    for (int k = 0; k < 4; k++) begin
      int rl, rm, rp, rr, rn, rs, nb;
      do_reset();
      rl = $urandom_range(1, 6); rm = $urandom_range(1, 3);
      rp = $urandom_range(0, 3); rr = $urandom_range(0, 3);
      rn = $urandom_range(1, 3); rs = $urandom_range(0, 6);
      for (int i = 0; i < rl; i++) write_ram(i, {$urandom, $urandom});
      $display("config l=%0d m=%0d p=%0d r=%0d nant=%0d spp=%0d", rl, rm, rp, rr, rn, rs);
      set_cfg(rl, rm, rp, rr, rn, rs);
      en = 1'b1;
      model_frame(rl, rm, rp, rr, rn, rs, 1'b0);
      model_frame(rl, rm, rp, rr, rn, rs, 1'b0);
      nb = exp_q.size();
      run_beats(nb, 1'b1, 0, 3000);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
